// File: rtl/ps2_rx_pkg.sv
// ps2_rx_pkg: frame states, PS/2 frame constants and odd-parity helper shared by the receiver
package ps2_rx_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_rx_state_t;
  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;
  function automatic logic parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: show-ahead FIFO; in clk/reset/push/pop/din, out dout(head)/full/empty/count
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;

  always_comb begin
    empty   = cnt_q == '0;
    full    = cnt_q == (AW+1)'(DEPTH);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d  = wr_q + AW'(do_push);
    rd_d  = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 receiver; raw ps2_clk_in/ps2_dat_in -> filtered 11-bit frames -> byte_fifo (pop/data_out/data_valid/count) with sticky parity/frame/overflow flags
module ps2_rx
  import ps2_rx_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2_clk_in,
  input  logic                          ps2_dat_in,
  input  logic                          inhibit,
  input  logic                          pop,
  input  logic                          clear_errors,
  output logic [PS2_DATA_BITS-1:0]      data_out,
  output logic                          data_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          parity_error,
  output logic                          frame_error,
  output logic                          overflow
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  ps2_rx_state_t state_q, state_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
  logic par_q, par_d;
  logic [TW-1:0] to_q, to_d;
  logic perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
  logic s_clk, s_dat, flip, fall, push, perr_set, ferr_set, full, empty;

  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_in};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_in};
    s_clk      = clk_sync_q[SYNC_STAGES-1];
    s_dat      = dat_sync_q[SYNC_STAGES-1];
    flip       = (s_clk != filt_q) && (filt_cnt_q == FW'(FILTER_LEN - 1));
    filt_cnt_d = (s_clk == filt_q || flip) ? '0 : filt_cnt_q + 1'b1;
    filt_d     = flip ? s_clk : filt_q;
    fall       = flip & filt_q & ~inhibit;
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    push       = 1'b0;
    perr_set   = 1'b0;
    ferr_set   = 1'b0;
    to_d       = (state_q == IDLE || fall) ? '0 : to_q + 1'b1;
    if (inhibit) begin
      state_d = IDLE;
      to_d    = '0;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          ferr_set  = s_dat;
          state_d   = s_dat ? IDLE : DATA;
          bit_idx_d = '0;
        end
        DATA: begin
          shift_d   = {s_dat, shift_q[PS2_DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          state_d   = (bit_idx_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_d   = s_dat;
          state_d = STOP;
        end
        default: begin
          state_d  = IDLE;
          ferr_set = ~s_dat;
          perr_set = ~parity_ok(shift_q, par_q);
          push     = s_dat & parity_ok(shift_q, par_q);
        end
      endcase
    end else if (state_q != IDLE && to_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d  = IDLE;
      ferr_set = 1'b1;
      to_d     = '0;
    end
    // a set event in the same cycle as clear_errors wins
    perr_d = perr_set | (perr_q & ~clear_errors);
    ferr_d = ferr_set | (ferr_q & ~clear_errors);
    ovf_d  = (push & full & ~pop) | (ovf_q & ~clear_errors);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      state_q    <= IDLE;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      to_q       <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      to_q       <= to_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
    end
  end

  byte_fifo #(.WIDTH(PS2_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (shift_q),
    .dout  (data_out),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign data_valid   = ~empty;
  assign parity_error = perr_q;
  assign frame_error  = ferr_q;
  assign overflow     = ovf_q;
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: table-driven frame vectors plus corner sequences, checked against a byte-queue scoreboard
module tb_ps2_rx;
  import ps2_rx_pkg::*;
  localparam int DEPTH = 4;
  localparam int TOUT  = 400;
  localparam int HP    = 20;
  logic clk = 1'b0, reset = 1'b1, pclk = 1'b1, dat = 1'b1, inhibit = 1'b0, pop = 1'b0, clr = 1'b0;
  logic [7:0] data_out;
  logic data_valid, parity_error, frame_error, overflow;
  logic [$clog2(DEPTH):0] count;
  int checks = 0, errors = 0;
  logic [7:0] model [$];
  bit e_perr = 0, e_ferr = 0, e_ovf = 0;

  typedef struct {
    logic [7:0] d;
    bit pflip;
    bit stop;
    bit e_push;
    bit e_perr;
    bit e_ferr;
  } vec_t;
  vec_t vecs [7];

  ps2_rx #(.SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYCLES(TOUT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ps2_clk_in(pclk), .ps2_dat_in(dat), .inhibit(inhibit),
    .pop(pop), .clear_errors(clr), .data_out(data_out), .data_valid(data_valid),
    .count(count), .parity_error(parity_error), .frame_error(frame_error), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, " count"}, 32'(count), 32'(model.size()));
    check({tag, " data_valid"}, 32'(data_valid), 32'(model.size() > 0));
    if (model.size() > 0) check({tag, " data_out"}, 32'(data_out), 32'(model[0]));
    check({tag, " parity_error"}, 32'(parity_error), 32'(e_perr));
    check({tag, " frame_error"}, 32'(frame_error), 32'(e_ferr));
    check({tag, " overflow"}, 32'(overflow), 32'(e_ovf));
  endtask

  task automatic send_bit(input logic b);
    dat = b;
    tick(HP);
    pclk = 1'b0;
    tick(HP);
    pclk = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] d, input bit pflip, input bit stop, input int nbits);
    logic [PS2_FRAME_BITS-1:0] f;
    f = {stop, ~^d ^ pflip, d, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i]);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pflip, input bit stop);
    send_bits(d, pflip, stop, PS2_FRAME_BITS);
    dat = 1'b1;
    tick(HP);
  endtask

  task automatic push_model(input logic [7:0] d);
    if (model.size() < DEPTH) model.push_back(d);
    else e_ovf = 1;
  endtask

  task automatic pop_one(input string tag);
    check({tag, " head"}, 32'(data_out), 32'(model[0]));
    pop = 1'b1;
    tick(1);
    pop = 1'b0;
    void'(model.pop_front());
    check({tag, " count after pop"}, 32'(count), 32'(model.size()));
  endtask

  task automatic clear_flags();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    e_perr = 0;
    e_ferr = 0;
    e_ovf  = 0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{8'h7E, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tick(3);
    check("reset data_out", 32'(data_out), 32'h0);
    check_state("reset");
    reset = 1'b0;
    tick(5);
    check_state("post reset");

    foreach (vecs[k]) begin
      send_frame(vecs[k].d, vecs[k].pflip, vecs[k].stop);
      if (vecs[k].e_push) push_model(vecs[k].d);
      e_perr |= vecs[k].e_perr;
      e_ferr |= vecs[k].e_ferr;
      tick(4);
      check_state($sformatf("vec%0d", k));
      while (model.size() > 0) pop_one($sformatf("vec%0d", k));
      pop = 1'b1;
      tick(1);
      pop = 1'b0;
      check($sformatf("vec%0d empty pop", k), 32'(count), 32'h0);
      clear_flags();
      check_state($sformatf("vec%0d cleared", k));
    end

    for (int b = 1; b <= 6; b++) begin
      send_frame(8'(b), 1'b0, 1'b1);
      push_model(8'(b));
    end
    check_state("overflow");
    clear_flags();
    send_bits(8'h07, 1'b0, 1'b1, PS2_FRAME_BITS - 1);
    check("full head before push+pop", 32'(data_out), 32'(model[0]));
    dat = 1'b1;
    tick(HP);
    pclk = 1'b0;
    tick(5);
    pop = 1'b1;
    tick(1);
    pop = 1'b0;
    tick(HP - 6);
    pclk = 1'b1;
    tick(HP);
    void'(model.pop_front());
    model.push_back(8'h07);
    check_state("full push+pop");
    while (model.size() > 0) pop_one("drain");

    send_bits(8'h6B, 1'b0, 1'b1, 5);
    tick(TOUT - 50);
    check_state("before timeout");
    tick(100);
    e_ferr = 1;
    check_state("timeout");
    clear_flags();
    send_frame(8'h7E, 1'b0, 1'b1);
    push_model(8'h7E);
    check_state("after timeout");
    pop_one("after timeout");

    send_bits(8'h33, 1'b0, 1'b1, 4);
    inhibit = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    tick(100);
    inhibit = 1'b0;
    tick(10);
    check_state("inhibit released");
    send_frame(8'hFA, 1'b0, 1'b1);
    push_model(8'hFA);
    check_state("after inhibit");
    pclk = 1'b0;
    tick(2);
    pclk = 1'b1;
    tick(20);
    check_state("glitch");
    send_frame(8'h12, 1'b0, 1'b1);
    push_model(8'h12);
    check_state("after glitch");
    pop_one("after glitch a");
    pop_one("after glitch b");

    send_frame(8'h99, 1'b0, 1'b1);
    push_model(8'h99);
    check_state("pre reset");
    send_bits(8'h99, 1'b0, 1'b1, 5);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    model.delete();
    check_state("mid reset");
    check("mid reset data_out", 32'(data_out), 32'h0);
    for (int i = 5; i < PS2_FRAME_BITS; i++) send_bit((i == 9) ? ~^8'h99 : 8'h99 >> (i - 1));
    dat = 1'b1;
    tick(TOUT + 50);
    check("reset tail count", 32'(count), 32'h0);
    check("reset tail parity_error", 32'(parity_error), 32'h0);
    check("reset tail overflow", 32'(overflow), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
